// File: rtl/periph_axil_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : periph_axil_responder_pkg
// Description : Shared types and constants for the peripheral AXI4-Lite
//               responder: response codes, FSM encodings, window base and
//               window-relative address arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package periph_axil_responder_pkg;

  // Base of the peripheral window on the core's peripheral bus
  localparam logic [31:0] PERIPHERAL_BUS_ADDR = 32'h6000_0000;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_t;

  // Write-channel FSM encoding
  typedef logic [1:0] wr_state_t;
  localparam wr_state_t WR_IDLE      = 2'd0;
  localparam wr_state_t WR_HAVE_ADDR = 2'd1;
  localparam wr_state_t WR_HAVE_DATA = 2'd2;
  localparam wr_state_t WR_RESP      = 2'd3;

  // Read-channel FSM encoding
  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_RESP = 1'b1;

  // Window-relative offset in 33 bits; an address below the base wraps to a
  // huge value, so a single range compare rejects it
  function automatic logic [32:0] addr_offset(input logic [31:0] addr,
                                              input logic [31:0] base);
    return {1'b0, addr} - {1'b0, base};
  endfunction

endpackage
`default_nettype wire

// File: rtl/periph_axil_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : periph_axil_responder_if
// Description : AXI4-Lite bus bundle between the peripheral-bus initiator
//               (master) and the register responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface periph_axil_responder_if;
  import periph_axil_responder_pkg::*;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  axi_resp_t   bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  axi_resp_t   rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

endinterface
`default_nettype wire

// File: rtl/periph_axil_reg_bank.sv
`default_nettype none
// ============================================================================
// Module      : periph_axil_reg_bank
// Description : Register storage for the peripheral responder. Word 0 is a
//               constant ID, words 1..NUM_REGS-1 are byte-writable. Provides
//               a combinational read mux and a flattened export of all words.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_axil_reg_bank
  import periph_axil_responder_pkg::*;
#(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'h0000_0000
) (
  input  wire logic                        clk,
  input  wire logic                        rst_n,
  input  wire logic                        wr_en,
  input  wire logic [$clog2(NUM_REGS)-1:0] wr_idx,
  input  wire logic [31:0]                 wr_data,
  input  wire logic [3:0]                  wr_strb,
  input  wire logic [$clog2(NUM_REGS)-1:0] rd_idx,
  output logic      [31:0]                 rd_data,
  output logic      [NUM_REGS*32-1:0]      regs_o
);

  localparam int c_idx_w = $clog2(NUM_REGS);

  logic [NUM_REGS-1:0][31:0] w_words;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_word
    if (gi == 0) begin : g_ro
      assign w_words[gi] = ID_VALUE;
    end else begin : g_rw
      logic [31:0] r_word;

      // Byte-strobed update of one scratch/control word
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_word <= '0;
        end else if (wr_en && (wr_idx == c_idx_w'(gi))) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) begin
              r_word[8*b +: 8] <= wr_data[8*b +: 8];
            end
          end
        end
      end

      assign w_words[gi] = r_word;
    end
  end

  assign rd_data = w_words[rd_idx];
  assign regs_o  = w_words;

endmodule
`default_nettype wire

// File: rtl/periph_axil_responder.sv
`default_nettype none
// ============================================================================
// Module      : periph_axil_responder
// Description : AXI4-Lite responder for the peripheral window. Independent
//               write and read FSMs, one outstanding transaction per channel,
//               address decode with SLVERR on miss, register bank below.
// Revision    : 1.0 - initial release
// ============================================================================
module periph_axil_responder
  import periph_axil_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = PERIPHERAL_BUS_ADDR,
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] ID_VALUE  = 32'h0000_0000
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  periph_axil_responder_if.slave      bus,
  output logic [NUM_REGS*32-1:0]      regs_o
);

  localparam int          c_idx_w = $clog2(NUM_REGS);
  localparam logic [32:0] c_span  = 33'(NUM_REGS * 4);

  // ---------------------------------------------------------------- write side
  wr_state_t     r_wr_state;
  logic [31:0]   r_aw_addr;
  logic [31:0]   r_w_data;
  logic [3:0]    r_w_strb;
  axi_resp_t     r_bresp;

  logic          w_aw_hs;
  logic          w_w_hs;
  logic          w_commit;
  logic [31:0]   w_commit_addr;
  logic [31:0]   w_commit_data;
  logic [3:0]    w_commit_strb;
  logic [32:0]   w_wr_off;
  logic          w_wr_hit;
  logic [c_idx_w-1:0] w_wr_idx;

  assign bus.awready = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_DATA);
  assign bus.wready  = (r_wr_state == WR_IDLE) || (r_wr_state == WR_HAVE_ADDR);
  assign bus.bvalid  = (r_wr_state == WR_RESP);
  assign bus.bresp   = r_bresp;

  assign w_aw_hs = bus.awvalid && bus.awready;
  assign w_w_hs  = bus.wvalid  && bus.wready;

  // Pick the commit operands: live bus values or whichever half was latched
  always_comb begin
    w_commit      = 1'b0;
    w_commit_addr = bus.awaddr;
    w_commit_data = bus.wdata;
    w_commit_strb = bus.wstrb;
    case (r_wr_state)
      WR_IDLE: begin
        w_commit = w_aw_hs && w_w_hs;
      end
      WR_HAVE_ADDR: begin
        w_commit      = w_w_hs;
        w_commit_addr = r_aw_addr;
      end
      WR_HAVE_DATA: begin
        w_commit      = w_aw_hs;
        w_commit_data = r_w_data;
        w_commit_strb = r_w_strb;
      end
      default: begin
        w_commit = 1'b0;
      end
    endcase
  end

  assign w_wr_off = addr_offset(w_commit_addr, BASE_ADDR);
  assign w_wr_hit = (w_commit_addr >= BASE_ADDR) && (w_wr_off < c_span);
  assign w_wr_idx = w_wr_off[c_idx_w+1:2];

  // Write FSM: gather AW and W in either order, then hold B until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_state <= WR_IDLE;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      r_bresp    <= RESP_OKAY;
    end else begin
      case (r_wr_state)
        WR_IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_wr_state <= WR_RESP;
          end else if (w_aw_hs) begin
            r_aw_addr  <= bus.awaddr;
            r_wr_state <= WR_HAVE_ADDR;
          end else if (w_w_hs) begin
            r_w_data   <= bus.wdata;
            r_w_strb   <= bus.wstrb;
            r_wr_state <= WR_HAVE_DATA;
          end
        end
        WR_HAVE_ADDR: begin
          if (w_w_hs) r_wr_state <= WR_RESP;
        end
        WR_HAVE_DATA: begin
          if (w_aw_hs) r_wr_state <= WR_RESP;
        end
        WR_RESP: begin
          if (bus.bready) r_wr_state <= WR_IDLE;
        end
        default: begin
          r_wr_state <= WR_IDLE;
        end
      endcase
      if (w_commit) begin
        r_bresp <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  // ----------------------------------------------------------------- read side
  rd_state_t     r_rd_state;
  logic [31:0]   r_rdata;
  axi_resp_t     r_rresp;

  logic          w_ar_hs;
  logic [32:0]   w_rd_off;
  logic          w_rd_hit;
  logic [c_idx_w-1:0] w_rd_idx;
  logic [31:0]   w_rd_word;

  assign bus.arready = (r_rd_state == RD_IDLE);
  assign bus.rvalid  = (r_rd_state == RD_RESP);
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;

  assign w_ar_hs  = bus.arvalid && bus.arready;
  assign w_rd_off = addr_offset(bus.araddr, BASE_ADDR);
  assign w_rd_hit = (bus.araddr >= BASE_ADDR) && (w_rd_off < c_span);
  assign w_rd_idx = w_rd_off[c_idx_w+1:2];

  // Read FSM: capture the pre-edge register value, hold it until accepted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_state <= RD_IDLE;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            r_rdata    <= w_rd_hit ? w_rd_word : 32'h0;
            r_rresp    <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
            r_rd_state <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (bus.rready) r_rd_state <= RD_IDLE;
        end
        default: begin
          r_rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------ register bank
  periph_axil_reg_bank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_reg_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_commit && w_wr_hit),
    .wr_idx  (w_wr_idx),
    .wr_data (w_commit_data),
    .wr_strb (w_commit_strb),
    .rd_idx  (w_rd_idx),
    .rd_data (w_rd_word),
    .regs_o  (regs_o)
  );

`ifndef SYNTHESIS
  // Responses must not be withdrawn or altered before the initiator takes them
  a_bvalid_hold: assert property (@(posedge clk)
    (rst_n && bus.bvalid && !bus.bready) |=> (!rst_n || bus.bvalid));
  a_rvalid_hold: assert property (@(posedge clk)
    (rst_n && bus.rvalid && !bus.rready) |=> (!rst_n || bus.rvalid));
  a_bresp_stable: assert property (@(posedge clk)
    (rst_n && bus.bvalid && !bus.bready) |=> (!rst_n || $stable(bus.bresp)));
  a_rresp_stable: assert property (@(posedge clk)
    (rst_n && bus.rvalid && !bus.rready) |=> (!rst_n || $stable(bus.rresp)));
  a_rdata_stable: assert property (@(posedge clk)
    (rst_n && bus.rvalid && !bus.rready) |=> (!rst_n || $stable(bus.rdata)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_periph_axil_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_periph_axil_responder
// Description : Self-checking bench for periph_axil_responder: directed
//               scenarios plus randomized traffic against a queue-based
//               transaction model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_periph_axil_responder;

  localparam logic [31:0] c_base = 32'h6000_0000;
  localparam int          c_nr   = 8;
  localparam logic [31:0] c_id   = 32'hC0DE_0001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [c_nr*32-1:0] regs_o;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc_cnt = 0;

  periph_axil_responder_if bus();

  periph_axil_responder #(
    .BASE_ADDR (c_base),
    .NUM_REGS  (c_nr),
    .ID_VALUE  (c_id)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .regs_o (regs_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------------ model
  logic [31:0] m_regs [c_nr];
  logic [31:0] awq [$];
  logic [35:0] wq  [$];
  logic [1:0]  bq  [$];
  logic [33:0] rq  [$];
  bit          m_on = 1'b0;

  function automatic bit m_hit(input logic [31:0] a);
    longint unsigned x = a;
    longint unsigned b = c_base;
    return (x >= b) && (x < b + c_nr * 4);
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    logic [31:0] d = (a - c_base) >> 2;
    return int'(d[7:0]);
  endfunction

  // Compare outputs against the model, then advance the model with the
  // handshakes that the coming clock edge will see
  always @(negedge clk) begin
    if (m_on) begin
      chk("awready", 32'(bus.awready), 32'(bq.size() == 0 && awq.size() == 0));
      chk("wready",  32'(bus.wready),  32'(bq.size() == 0 && wq.size() == 0));
      chk("arready", 32'(bus.arready), 32'(rq.size() == 0));
      chk("bvalid",  32'(bus.bvalid),  32'(bq.size() != 0));
      chk("rvalid",  32'(bus.rvalid),  32'(rq.size() != 0));
      if (bq.size() != 0) chk("bresp", 32'(bus.bresp), 32'(bq[0]));
      if (rq.size() != 0) begin
        chk("rdata", bus.rdata, rq[0][31:0]);
        chk("rresp", 32'(bus.rresp), 32'(rq[0][33:32]));
      end
      for (int i = 0; i < c_nr; i++)
        chk($sformatf("regs_o[%0d]", i), regs_o[32*i +: 32], (i == 0) ? c_id : m_regs[i]);
    end
    if (!rst_n) begin
      awq.delete(); wq.delete(); bq.delete(); rq.delete();
      for (int i = 0; i < c_nr; i++) m_regs[i] = 32'h0;
      m_on = 1'b1;
    end else if (m_on) begin
      logic [31:0] a;
      logic [35:0] w;
      if (bq.size() != 0 && bus.bready) void'(bq.pop_front());
      if (rq.size() != 0 && bus.rready) void'(rq.pop_front());
      if (bus.arvalid && bus.arready) begin
        if (!m_hit(bus.araddr))             rq.push_back({2'b10, 32'h0});
        else if (m_idx(bus.araddr) == 0)    rq.push_back({2'b00, c_id});
        else                                rq.push_back({2'b00, m_regs[m_idx(bus.araddr)]});
      end
      if (bus.awvalid && bus.awready) awq.push_back(bus.awaddr);
      if (bus.wvalid && bus.wready)   wq.push_back({bus.wstrb, bus.wdata});
      if (awq.size() != 0 && wq.size() != 0) begin
        a = awq.pop_front();
        w = wq.pop_front();
        if (m_hit(a) && m_idx(a) != 0)
          for (int b = 0; b < 4; b++)
            if (w[32+b]) m_regs[m_idx(a)][8*b +: 8] = w[8*b +: 8];
        bq.push_back(m_hit(a) ? 2'b00 : 2'b10);
      end
    end
  end

  // ------------------------------------------------------------------ driver
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] a, output int e);
    bit hs = 1'b0;
    bus.awvalid = 1'b1;
    bus.awaddr  = a;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = bus.awready;
      cyc();
    end
    bus.awvalid = 1'b0;
    e = cyc_cnt;
    if (!hs) begin n_vec++; n_err++; $display("FAIL aw_timeout: got awready=0, expected 1"); end
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    bit hs = 1'b0;
    bus.wvalid = 1'b1;
    bus.wdata  = d;
    bus.wstrb  = s;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = bus.wready;
      cyc();
    end
    bus.wvalid = 1'b0;
    if (!hs) begin n_vec++; n_err++; $display("FAIL w_timeout: got wready=0, expected 1"); end
  endtask

  task automatic send_ar(input logic [31:0] a);
    bit hs = 1'b0;
    bus.arvalid = 1'b1;
    bus.araddr  = a;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = bus.arready;
      cyc();
    end
    bus.arvalid = 1'b0;
    if (!hs) begin n_vec++; n_err++; $display("FAIL ar_timeout: got arready=0, expected 1"); end
  endtask

  task automatic wait_b(input int hold, output logic [1:0] resp, output int e);
    bit seen = 1'b0;
    resp = 2'bxx;
    e = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.bvalid) seen = 1'b1;
      else cyc();
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL b_timeout: got bvalid=0, expected 1");
      return;
    end
    resp = bus.bresp;
    cyc();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("b_hold_bvalid",  32'(bus.bvalid),  32'd1);
      chk("b_hold_awready", 32'(bus.awready), 32'd0);
      chk("b_hold_wready",  32'(bus.wready),  32'd0);
      cyc();
    end
    bus.bready = 1'b1;
    cyc();
    e = cyc_cnt;
    bus.bready = 1'b0;
  endtask

  task automatic read_txn(input logic [31:0] a, input int hold,
                          output logic [31:0] d, output logic [1:0] r);
    bit seen = 1'b0;
    d = 'x;
    r = 'x;
    send_ar(a);
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.rvalid) seen = 1'b1;
      else cyc();
    end
    if (!seen) begin
      n_vec++; n_err++;
      $display("FAIL r_timeout: got rvalid=0, expected 1");
      return;
    end
    d = bus.rdata;
    r = bus.rresp;
    cyc();
    repeat (hold) cyc();
    bus.rready = 1'b1;
    cyc();
    bus.rready = 1'b0;
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int hold, output logic [1:0] resp);
    int e;
    int e2;
    fork
      begin repeat ((lead < 0) ? -lead : 0) cyc(); send_aw(a, e); end
      begin repeat ((lead > 0) ? lead : 0) cyc(); send_w(d, s); end
    join
    wait_b(hold, resp, e2);
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return c_base + 32'($urandom_range(0, c_nr - 1) * 4) + 32'($urandom_range(0, 3));
      3:       return c_base - 32'd4;
      4:       return c_base + 32'(c_nr * 4);
      default: return $urandom;
    endcase
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          e_b;
    int          e_aw;

    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready  = 1'b0;

    rst_n = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_awready", 32'(bus.awready), 32'd1);
    chk("rst_wready",  32'(bus.wready),  32'd1);
    chk("rst_arready", 32'(bus.arready), 32'd1);
    chk("rst_bvalid",  32'(bus.bvalid),  32'd0);
    chk("rst_rvalid",  32'(bus.rvalid),  32'd0);
    chk("rst_bresp",   32'(bus.bresp),   32'd0);
    chk("rst_rresp",   32'(bus.rresp),   32'd0);
    chk("rst_rdata",   bus.rdata,        32'd0);
    chk("rst_reg1",    regs_o[63:32],    32'd0);
    cyc();

    // AW and W together; response the cycle after the handshake
    fork
      send_aw(c_base + 32'd4, e_aw);
      send_w(32'hDEAD_BEEF, 4'hF);
    join
    @(negedge clk);
    chk("t1_bvalid_next", 32'(bus.bvalid), 32'd1);
    chk("t1_bresp",       32'(bus.bresp),  32'd0);
    wait_b(0, r, e_b);
    read_txn(c_base + 32'd4, 0, d, r);
    chk("t1_rdata", d, 32'hDEAD_BEEF);
    chk("t1_rresp", 32'(r), 32'd0);

    // W one cycle ahead of AW with partial strobes
    fork
      begin
        send_w(32'h1122_3344, 4'b0101);
        @(negedge clk);
        chk("t2_wready_wait", 32'(bus.wready), 32'd0);
      end
      begin cyc(); send_aw(c_base + 32'd8, e_aw); end
    join
    wait_b(0, r, e_b);
    @(negedge clk);
    chk("t2_single_bvalid", 32'(bus.bvalid), 32'd0);
    chk("t2_reg2", regs_o[95:64], 32'h0022_0044);
    cyc();

    // Backpressured response; a second AW waits until after bready
    fork
      send_aw(c_base + 32'd20, e_aw);
      send_w(32'h5555_AAAA, 4'hF);
    join
    fork
      wait_b(5, r, e_b);
      begin repeat (2) cyc(); send_aw(c_base + 32'd24, e_aw); end
    join
    chk("t3_bresp", 32'(r), 32'd0);
    chk("t3_aw_after_bready", 32'(e_aw), 32'(e_b + 1));
    send_w(32'h0000_0066, 4'h1);
    wait_b(0, r, e_b);
    chk("t3_second_bresp", 32'(r), 32'd0);

    // ID word is read-only but writes to it are acknowledged
    read_txn(c_base, 0, d, r);
    chk("t4_id", d, c_id);
    write_txn(c_base, 32'hFFFF_FFFF, 4'hF, 0, 0, r);
    chk("t4_id_wr_bresp", 32'(r), 32'd0);
    @(negedge clk);
    chk("t4_id_unchanged", regs_o[31:0], c_id);
    cyc();

    // Out-of-window accesses
    read_txn(c_base + 32'h20, 0, d, r);
    chk("t5_miss_rresp", 32'(r), 32'd2);
    chk("t5_miss_rdata", d, 32'd0);
    write_txn(32'h5FFF_FFFC, 32'h1234_5678, 4'hF, 0, 0, r);
    chk("t5_miss_bresp", 32'(r), 32'd2);

    // Same-cycle read and write of reg3 returns the old value
    write_txn(c_base + 32'd12, 32'h1, 4'hF, 0, 0, r);
    fork
      write_txn(c_base + 32'd12, 32'h2, 4'hF, 0, 0, r);
      read_txn(c_base + 32'd12, 0, d, r);
    join
    chk("t6_old_value", d, 32'h1);
    read_txn(c_base + 32'd12, 0, d, r);
    chk("t6_new_value", d, 32'h2);

    // Reset with a read response pending
    send_ar(c_base + 32'd12);
    @(negedge clk);
    chk("t7_rvalid_pending", 32'(bus.rvalid), 32'd1);
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t7_rvalid_dropped", 32'(bus.rvalid), 32'd0);
    for (int i = 1; i < c_nr; i++)
      chk($sformatf("t7_reg%0d_clear", i), regs_o[32*i +: 32], 32'd0);
    cyc();

    // Randomized traffic checked by the model
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 2))
        0: write_txn(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 4) - 2, $urandom_range(0, 3), r);
        1: read_txn(rand_addr(), $urandom_range(0, 3), d, r);
        default: fork
          write_txn(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 4) - 2, $urandom_range(0, 3), r);
          read_txn(rand_addr(), $urandom_range(0, 3), d, r);
        join
      endcase
    end

    repeat (3) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/periph_axil_responder.md
Name: periph_axil_responder

Overview:
- AXI4-Lite responder (slave) answering the core's peripheral-bus initiator; occupies the peripheral window starting at 0x6000_0000.
- Provides a small bank of 32-bit registers: word 0 is a read-only ID, words 1..NUM_REGS-1 are read/write scratch/control registers.
- Register contents are exported for use by SoC glue and simulation.
- Read and write channels are independent and each carries at most one outstanding transaction.

Parameters:
- BASE_ADDR, 32'h6000_0000, byte address of register 0; aligned to NUM_REGS*4.
- NUM_REGS, 8, number of 32-bit registers; power of 2, min 2.
- ID_VALUE, 32'h0000_0000, constant returned by register 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- awvalid/awready  in/out  1/1  write-address handshake
- awaddr  in  32  write byte address
- wvalid/wready  in/out  1/1  write-data handshake
- wdata  in  32  write data
- wstrb  in  4  byte enables
- bvalid/bready  out/in  1/1  write-response handshake
- bresp  out  2  OKAY=2'b00, SLVERR=2'b10
- arvalid/arready  in/out  1/1  read-address handshake
- araddr  in  32  read byte address
- rvalid/rready  out/in  1/1  read-response handshake
- rdata  out  32  read data
- rresp  out  2  OKAY/SLVERR
- regs_o  out  NUM_REGS*32  current register contents; word i at bits [32i+31:32i]; word 0 = ID_VALUE

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Write FSM → WR_IDLE, read FSM → RD_IDLE.
  - awready=wready=arready=1 from the first cycle after reset.
  - bvalid=rvalid=0; bresp=rresp=0; rdata=0.
  - Registers 1..N-1 = 0.
  - Reset mid-transaction drops it silently; no response is issued.
- Decode:
  - hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + NUM_REGS*4).
  - idx = (addr - BASE_ADDR)[log2(NUM_REGS)+1:2]; addr[1:0] ignored.
  - Miss → SLVERR.
- Write FSM states: WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP.
  - WR_IDLE: awready=1, wready=1.
    - AW and W both handshake in the same cycle → commit at that edge, go WR_RESP.
    - AW only → latch address, go WR_HAVE_ADDR.
    - W only → latch data/strobe, go WR_HAVE_DATA.
  - WR_HAVE_ADDR: awready=0, wready=1; W handshake → commit, go WR_RESP.
  - WR_HAVE_DATA: wready=0, awready=1; AW handshake → commit, go WR_RESP.
  - Commit: for each byte b with wstrb[b]=1 and hit && idx!=0, reg[idx].byte[b] = wdata.byte[b].
  - Commit response: bresp=OKAY if hit (including idx 0, where the write is ignored), else SLVERR.
  - WR_RESP: bvalid=1, awready=wready=0; bresp stable until bready. bready=1 → WR_IDLE (bvalid=0 next cycle).
  - Max throughput: one write per 2 cycles. bvalid is asserted the cycle after the later handshake.
- Read FSM states: RD_IDLE, RD_RESP.
  - RD_IDLE: arready=1. Handshake → rdata = hit ? reg[idx] : 0, rresp = hit ? OKAY : SLVERR; go RD_RESP.
  - RD_RESP: rvalid=1, arready=0; rdata/rresp stable until rready. rready → RD_IDLE.
- Simultaneous read handshake and write commit to the same register in the same cycle: read returns the pre-write value; the write takes effect from the next cycle. regs_o updates the cycle after commit.
- Address arithmetic is done in 33 bits so BASE_ADDR+NUM_REGS*4 cannot wrap past 2^32.
- Protocol assertions (simulation only):
  - bvalid/rvalid never drop without the matching ready.
  - bresp, rresp and rdata stable while valid && !ready.

Decomposition:
- Shared bus package:
  - axi_resp_t enum {RESP_OKAY=2'b00, RESP_SLVERR=2'b10}.
  - Write-state and read-state enums.
  - Peripheral-window constant taken from PERIPHERAL_BUS_ADDR.
- Sub-module periph_axil_reg_bank: register storage, byte-strobe merge, RO word 0, read mux, regs_o flattening.
- The responder top holds the two FSMs and the decode logic.

Test Plan:
- Reset, then AW+W same cycle, addr 0x6000_0004, wdata 0xDEADBEEF, strb 4'hF → bvalid next cycle, bresp=00; read 0x6000_0004 returns 0xDEADBEEF, rresp=00.
- W one cycle before AW (addr 0x6000_0008, data 0x11223344, strb 4'b0101) → reg2=0x00220044; wready=0 while waiting for AW; one bvalid only.
- bready held low 5 cycles → bvalid and bresp stable; awready=wready=0 throughout; a second AW is not accepted until the cycle after bready.
- Read 0x6000_0000 → ID_VALUE; write 0xFFFF_FFFF to 0x6000_0000 → bresp=00, reg0 unchanged.
- Read 0x6000_0020 and write 0x5FFF_FFFC → SLVERR, rdata=0, no register modified.
- Read and write of reg3 in the same cycle (old value 0x1, new 0x2) → rdata=0x1; the next read returns 0x2. Apply rst_n=0 while rvalid pending → rvalid=0 and regs cleared next cycle.
